// File: rtl/prbs_checker_if.sv
// Link-test receive interface: serial bit stream in, lock status and error counters out.
// The master drives the stream and the counter clear; the slave is the checker.
interface prbs_checker_if #(
  parameter int ERR_W = 16
);
  logic             bit_in;
  logic             bit_vld;
  logic             clr_cnt;
  logic             locked;
  logic             err_pulse;
  logic             lost;
  logic [ERR_W-1:0] err_cnt;

  modport master (
    output bit_in, bit_vld, clr_cnt,
    input  locked, err_pulse, lost, err_cnt
  );

  modport slave (
    input  bit_in, bit_vld, clr_cnt,
    output locked, err_pulse, lost, err_cnt
  );
endinterface

// File: rtl/prbs_checker.sv
// Self-synchronising checker for the 6-bit Galois LFSR stream (e = b[-2]^b[-5]^b[-6]).
// The FSM runs SEED -> HUNT -> LOCKED, then counts errors against a free-running prediction.
module prbs_checker #(
  parameter int LOCK_CNT = 8,
  parameter int WIN      = 32,
  parameter int LOSS_THR = 4,
  parameter int ERR_W    = 16
) (
  input  logic           clk,
  input  logic           rst_b,
  prbs_checker_if.slave  link
);

  localparam int RUN_W = $clog2(LOCK_CNT + 1);
  localparam int WP_W  = $clog2(WIN + 1);
  localparam int WE_W  = $clog2(LOSS_THR + 1);

  typedef enum logic [1:0] {
    SEED   = 2'd0,
    HUNT   = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t             state_q;
  logic [5:0]         hist_q;
  logic [2:0]         fill_cnt_q;
  logic [RUN_W-1:0]   run_cnt_q;
  logic [WP_W-1:0]    win_pos_q;
  logic [WE_W-1:0]    win_err_q;
  logic               locked_q;
  logic               err_pulse_q;
  logic               lost_q;
  logic [ERR_W-1:0]   err_cnt_q;

  // hist_q[0] is the newest bit b[-1], hist_q[5] the oldest b[-6]
  logic               exp_bit;
  logic               mis;
  logic               hist_ok;
  logic               match;
  logic [WE_W-1:0]    win_err_d;
  logic               loss;
  logic               err_inc;
  logic [ERR_W-1:0]   err_cnt_d;

  assign exp_bit   = hist_q[1] ^ hist_q[4] ^ hist_q[5];
  assign mis       = link.bit_in ^ exp_bit;
  // A legal stream never holds six equal bits, so this rejects stuck-at inputs
  assign hist_ok   = (hist_q != 6'h00) && (hist_q != 6'h3f);
  assign match     = !mis && hist_ok;
  assign win_err_d = win_err_q + WE_W'(mis);
  assign loss      = (win_err_d >= WE_W'(LOSS_THR));
  assign err_inc   = link.bit_vld && (state_q == LOCKED) && mis && !(&err_cnt_q);

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (link.clr_cnt)  err_cnt_d = '0;
    else if (err_inc)  err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q     <= SEED;
      hist_q      <= '0;
      fill_cnt_q  <= '0;
      run_cnt_q   <= '0;
      win_pos_q   <= '0;
      win_err_q   <= '0;
      locked_q    <= 1'b0;
      err_pulse_q <= 1'b0;
      lost_q      <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      lost_q      <= 1'b0;
      err_cnt_q   <= err_cnt_d;
      if (link.bit_vld) begin
        case (state_q)
          SEED: begin
            hist_q     <= {hist_q[4:0], link.bit_in};
            fill_cnt_q <= fill_cnt_q + 3'd1;
            if (fill_cnt_q == 3'd5) state_q <= HUNT;
          end
          HUNT: begin
            hist_q <= {hist_q[4:0], link.bit_in};
            if (match) begin
              if (run_cnt_q == RUN_W'(LOCK_CNT - 1)) begin
                state_q   <= LOCKED;
                locked_q  <= 1'b1;
                run_cnt_q <= '0;
                win_pos_q <= '0;
                win_err_q <= '0;
              end else begin
                run_cnt_q <= run_cnt_q + 1'b1;
              end
            end else begin
              run_cnt_q <= '0;
            end
          end
          LOCKED: begin
            // Feed the prediction back, not the received bit, so one error stays one error
            hist_q      <= {hist_q[4:0], exp_bit};
            err_pulse_q <= mis;
            if (loss) begin
              state_q    <= SEED;
              locked_q   <= 1'b0;
              lost_q     <= 1'b1;
              hist_q     <= '0;
              fill_cnt_q <= '0;
              run_cnt_q  <= '0;
              win_pos_q  <= '0;
              win_err_q  <= '0;
            end else if (win_pos_q == WP_W'(WIN - 1)) begin
              win_pos_q <= '0;
              win_err_q <= '0;
            end else begin
              win_pos_q <= win_pos_q + 1'b1;
              win_err_q <= win_err_d;
            end
          end
          default: state_q <= SEED;
        endcase
      end
    end
  end

  assign link.locked    = locked_q;
  assign link.err_pulse = err_pulse_q;
  assign link.lost      = lost_q;
  assign link.err_cnt   = err_cnt_q;

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial receive-side checker for the 6-bit pseudo-random bit stream produced by the team's Galois LFSR generator. The generator's serial output is its MSB state bit, one bit per clock, from the all-ones reset state. The block self-synchronises to that stream, declares lock, then counts bit errors against a free-running local prediction. It sits at the receive end of the link-test path and feeds status and error counters to the test controller.

## Interface
Parameters:
- LOCK_CNT, 8: consecutive matches in HUNT required to declare lock
- WIN, 32: loss-detection window length, in valid bits
- LOSS_THR, 4: mismatches within one window that force loss of lock
- ERR_W, 16: width of err_cnt

Ports:
- clk  in  1  clock, rising edge
- rst_b  in  1  reset, asynchronous, active-low
- bit_in  in  1  received serial bit
- bit_vld  in  1  bit_in is valid this cycle
- clr_cnt  in  1  synchronous clear of err_cnt
- locked  out  1  checker is in LOCKED state
- err_pulse  out  1  one-cycle flag: mismatch on the bit sampled at the previous edge
- lost  out  1  one-cycle flag: lock dropped at the previous edge
- err_cnt  out  ERR_W  saturating count of mismatches while locked

## Operation
- Stream recurrence, with b[-1] the newest accepted bit: expected e = b[-2] ^ b[-5] ^ b[-6]. From reset the generator emits 1,1,0,0,1,0,1, repeating with period 7.
- hist: 6-bit history register holding the last six bits.
- State SEED:
  - Each valid bit shifts into hist and increments fill_cnt.
  - On the 6th valid bit the state moves to HUNT. No comparison is made in SEED.
- State HUNT:
  - Each valid bit is compared with e.
  - A match requires bit_in == e and hist not all-zeros and not all-ones. This rejects stuck-at-0 and stuck-at-1 inputs; the legal stream never contains 6 equal bits.
  - A match increments run_cnt; a non-match clears it.
  - bit_in is always shifted into hist.
  - On the LOCK_CNT-th consecutive match: state becomes LOCKED, locked=1, win_pos=0, win_err=0.
- State LOCKED:
  - hist shifts in e, not bit_in, so there is no error multiplication.
  - A mismatch sets err_pulse=1, increments err_cnt (saturating at all-ones) and increments win_err.
  - Each valid bit increments win_pos. The WIN-th bit of a window clears win_pos and win_err after that bit's own evaluation.
  - If win_err reaches LOSS_THR, counting the current bit: state becomes SEED, locked=0, lost=1, and hist, fill_cnt and run_cnt are cleared. err_cnt is retained.
- bit_vld=0: no state, history or counter changes; err_pulse=0 and lost=0.
- clr_cnt=1: err_cnt becomes 0. When clr_cnt coincides with an increment, the clear wins and err_cnt=0. err_pulse is unaffected.

## Timing
- All outputs are registered and update on the rising edge that samples bit_vld=1. There is one cycle of latency from bit presentation to flag visibility.
- Reset values: state=SEED, hist=0, fill_cnt=0, run_cnt=0, win_pos=0, win_err=0, locked=0, err_pulse=0, lost=0, err_cnt=0.
- Reset asserted mid-operation clears everything asynchronously, without waiting for clk. The first edge after release is treated as a SEED bit if bit_vld=1.
- Fastest lock from reset with a clean, contiguous stream: locked rises at the edge sampling valid bit number 6+LOCK_CNT, i.e. bit 14 with the defaults.
- err_pulse and lost are high for exactly one cycle per event, even if bit_vld stays high.
- Loss and a window wrap on the same bit: loss takes priority; the window counters are cleared by the SEED transition.
- Saturated err_cnt holds at 2^ERR_W-1 until clr_cnt or reset.

## Test plan
1. Reset, then a continuous stream 1,1,0,0,1,0,1 repeating for 200 bits -> locked=1 at the edge sampling bit 14; err_cnt=0 and lost never asserts.
2. After lock, invert a single bit -> err_pulse high for one cycle, err_cnt=1, locked stays 1, and no further errors follow (no multiplication).
3. 100 bits of constant 0, then 100 bits of constant 1 -> locked never asserts; err_cnt=0.
4. After lock, invert 4 bits within one 32-bit window -> on the 4th error lost=1 for one cycle and locked=0. Clean bits then relock 14 bits later, with err_cnt=4 preserved. Repeating with the 4 errors split 2+2 across a window boundary -> no loss; err_cnt=8.
5. bit_vld toggling every other cycle with the clean stream -> lock occurs on the 14th valid bit. clr_cnt asserted on the same edge as an error -> err_cnt=0 and err_pulse=1.
6. rst_b driven low between clock edges while LOCKED with err_cnt=5 -> locked=0 and err_cnt=0 immediately. Relock after 14 valid bits following release.
